// File: rtl/snow64_instr_decoder_pkg.sv
// -----------------------------------------------------------------------------
// PkgSnow64InstrDecoder (slice)
//   Shared instruction/address width constants owned by the decoder side.
//   The fetch front end derives its own widths from these so both blocks
//   stay in step if the ISA widths ever change.
// -----------------------------------------------------------------------------
package PkgSnow64InstrDecoder;
    localparam int WIDTH__INSTR = 32;
    localparam int WIDTH__ADDR  = 64;
endpackage

// File: rtl/snow64_instr_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// PkgSnow64InstrFetch
//   Types and constants for the instruction fetch queue:
//     FetchState      - fetch FSM state {IDLE, REQ, WAIT, DISCARD}
//     FetchQueueEntry - one queued {instr, pc} pair
//     fetch_align     - clear the in-word offset of a byte address
// -----------------------------------------------------------------------------
package PkgSnow64InstrFetch;
    localparam int WIDTH__INSTR    = PkgSnow64InstrDecoder::WIDTH__INSTR;
    localparam int WIDTH__ADDR     = PkgSnow64InstrDecoder::WIDTH__ADDR;
    localparam int WIDTH__MEM_WORD = 2 * WIDTH__INSTR;
    localparam int INSTR_BYTES     = WIDTH__INSTR / 8;
    localparam int WORD_BYTES      = WIDTH__MEM_WORD / 8;

    localparam logic [WIDTH__ADDR-1:0] FETCH_ADDR_MASK = ~(WIDTH__ADDR'(WORD_BYTES - 1));

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } FetchState;

    typedef struct packed {
        logic [WIDTH__INSTR-1:0] instr;
        logic [WIDTH__ADDR-1:0]  pc;
    } FetchQueueEntry;

    function automatic logic [WIDTH__ADDR-1:0] fetch_align(input logic [WIDTH__ADDR-1:0] a);
        return a & FETCH_ADDR_MASK;
    endfunction
endpackage

// File: rtl/snow64_instr_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// snow64_instr_fetch_fifo
//   DEPTH-entry FIFO of {instr, pc} with synchronous flush, 2-wide push and
//   1-wide pop. The head is read straight out of the storage registers, so a
//   word pushed in cycle M is visible at the head in cycle M+1.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   flush_i            drop all entries next cycle (beats push and pop)
//   push_lo_i, lo_i    push first entry
//   push_hi_i, hi_i    push second entry (lands behind lo_i when both push)
//   pop_i              consume head (ignored when empty)
//   head_o, valid_o    head entry and non-empty flag
//   count_o            current occupancy
//   count_next_o       occupancy after this cycle's push/pop/flush
// -----------------------------------------------------------------------------
module snow64_instr_fetch_fifo
    import PkgSnow64InstrFetch::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           push_lo_i,
    input  logic           push_hi_i,
    input  FetchQueueEntry lo_i,
    input  FetchQueueEntry hi_i,
    input  logic           pop_i,
    output FetchQueueEntry head_o,
    output logic           valid_o,
    output logic [CW-1:0]  count_o,
    output logic [CW-1:0]  count_next_o
);
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q, wr_hi_ptr;
    logic [CW-1:0]  count_q;
    logic           pop_ok;
    FetchQueueEntry mem_q [DEPTH];

    assign pop_ok       = pop_i & (count_q != '0);
    // The high word follows the low word only when the low word is pushed too.
    assign wr_hi_ptr    = wr_ptr_q + PW'(push_lo_i);
    assign count_next_o = flush_i ? '0
                        : count_q + CW'(push_lo_i) + CW'(push_hi_i) - CW'(pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_lo_i) mem_q[wr_ptr_q]  <= lo_i;
            if (push_hi_i) mem_q[wr_hi_ptr] <= hi_i;
            wr_ptr_q <= wr_hi_ptr + PW'(push_hi_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_ok);
            count_q  <= count_next_o;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/snow64_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// snow64_instr_fetch_queue
//   Fetches 64-bit words, splits them into two 32-bit instructions (low word at
//   the lower address), queues {instr, pc} and hands them to the decoder one
//   per cycle. A redirect flushes the queue and restarts fetch at a new PC.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_redirect_valid/_pc            flush + restart fetch (pc[1:0] ignored)
//   out_mem_req_valid/_addr          registered fetch request, 8-byte aligned
//   in_mem_req_ready                 memory takes the request this cycle
//   in_mem_resp_valid/_data          fetched 64-bit word
//   out_instr_valid/_instr/_instr_pc queue head to the decoder
//   in_decoder_ready                 decoder consumes the head
// Optional (macro SNOW64_INSTR_FETCH_PERF_CNT_EN):
//   out_perf_empty_cycles [31:0]     saturating count of cycles with no head
//   out_perf_discards     [15:0]     saturating count of dropped responses
// -----------------------------------------------------------------------------
module snow64_instr_fetch_queue
    import PkgSnow64InstrFetch::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [WIDTH__ADDR-1:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_redirect_valid,
    input  logic [WIDTH__ADDR-1:0]     in_redirect_pc,
    output logic                       out_mem_req_valid,
    output logic [WIDTH__ADDR-1:0]     out_mem_req_addr,
    input  logic                       in_mem_req_ready,
    input  logic                       in_mem_resp_valid,
    input  logic [WIDTH__MEM_WORD-1:0] in_mem_resp_data,
    output logic                       out_instr_valid,
    output logic [WIDTH__INSTR-1:0]    out_instr,
    output logic [WIDTH__ADDR-1:0]     out_instr_pc,
    input  logic                       in_decoder_ready
`ifdef SNOW64_INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                out_perf_empty_cycles,
    output logic [15:0]                out_perf_discards
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WIDTH__ADDR-1:0] RESET_FETCH_PC = RESET_PC & FETCH_ADDR_MASK;

    FetchState              state_q;
    logic [WIDTH__ADDR-1:0] fetch_pc_q, req_addr_q;
    logic                   req_valid_q, skip_low_q;

    logic           handshake, resp_accept, push_lo, push_hi, room;
    logic [CW-1:0]  count, count_next;
    FetchQueueEntry ent_lo, ent_hi, head;

    assign handshake   = req_valid_q & in_mem_req_ready;
    // A response is only consumed as real data in WAIT without a redirect.
    assign resp_accept = (state_q == WAIT) & in_mem_resp_valid & ~in_redirect_valid;
    assign push_lo     = resp_accept & ~skip_low_q;
    assign push_hi     = resp_accept;
    // Room for a full 2-word response, judged on next cycle's occupancy so a
    // request raised now can never overfill the queue.
    assign room        = (count_next <= CW'(DEPTH - 2));

    assign ent_lo = '{instr: in_mem_resp_data[WIDTH__INSTR-1:0], pc: req_addr_q};
    assign ent_hi = '{instr: in_mem_resp_data[WIDTH__MEM_WORD-1:WIDTH__INSTR],
                      pc:    req_addr_q + WIDTH__ADDR'(INSTR_BYTES)};

    snow64_instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (in_redirect_valid),
        .push_lo_i    (push_lo),
        .push_hi_i    (push_hi),
        .lo_i         (ent_lo),
        .hi_i         (ent_hi),
        .pop_i        (in_decoder_ready),
        .head_o       (head),
        .valid_o      (out_instr_valid),
        .count_o      (count),
        .count_next_o (count_next)
    );

    assign out_instr    = head.instr;
    assign out_instr_pc = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_FETCH_PC;
            req_addr_q  <= RESET_FETCH_PC;
            req_valid_q <= 1'b0;
            skip_low_q  <= RESET_PC[2];
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                end
                REQ: begin
                    if (handshake) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                        fetch_pc_q  <= fetch_pc_q + WIDTH__ADDR'(WORD_BYTES);
                    end else begin
                        // The queue only drains in REQ, so once raised this holds.
                        req_valid_q <= room;
                    end
                end
                WAIT: begin
                    if (in_mem_resp_valid) begin
                        state_q     <= REQ;
                        skip_low_q  <= 1'b0;
                        req_addr_q  <= fetch_pc_q;
                        req_valid_q <= room;
                    end
                end
                DISCARD: begin
                    if (in_mem_resp_valid) begin
                        state_q     <= REQ;
                        req_addr_q  <= fetch_pc_q;
                        req_valid_q <= room;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Redirect overrides everything above; the queue is empty next cycle.
            if (in_redirect_valid) begin
                fetch_pc_q <= fetch_align(in_redirect_pc);
                req_addr_q <= fetch_align(in_redirect_pc);
                skip_low_q <= in_redirect_pc[2];
                case (state_q)
                    REQ: begin
                        state_q     <= handshake ? DISCARD : REQ;
                        req_valid_q <= ~handshake;
                    end
                    // A response landing with the redirect settles the one
                    // outstanding request, so fetch can restart immediately.
                    WAIT, DISCARD: begin
                        state_q     <= in_mem_resp_valid ? REQ : DISCARD;
                        req_valid_q <= in_mem_resp_valid;
                    end
                    default: begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign out_mem_req_valid = req_valid_q;
    assign out_mem_req_addr  = req_addr_q;

`ifdef SNOW64_INSTR_FETCH_PERF_CNT_EN
    logic [31:0] perf_empty_q;
    logic [15:0] perf_disc_q;
    logic        resp_drop;

    assign resp_drop = in_mem_resp_valid &
                       ((state_q == DISCARD) | ((state_q == WAIT) & in_redirect_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_empty_q <= '0;
            perf_disc_q  <= '0;
        end else begin
            if (!out_instr_valid && perf_empty_q != '1) perf_empty_q <= perf_empty_q + 32'd1;
            if (resp_drop && perf_disc_q != '1)         perf_disc_q  <= perf_disc_q + 16'd1;
        end
    end

    assign out_perf_empty_cycles = perf_empty_q;
    assign out_perf_discards     = perf_disc_q;
`endif

    logic unused_count;
    assign unused_count = ^count;
endmodule

// File: tb/tb_snow64_instr_fetch_queue.sv
module tb_snow64_instr_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_redirect_valid = 1'b0;
    logic [63:0] in_redirect_pc = '0;
    logic        out_mem_req_valid;
    logic [63:0] out_mem_req_addr;
    logic        in_mem_req_ready = 1'b0, in_mem_resp_valid = 1'b0;
    logic [63:0] in_mem_resp_data = '0;
    logic        out_instr_valid;
    logic [31:0] out_instr;
    logic [63:0] out_instr_pc;
    logic        in_decoder_ready = 1'b0;
`ifdef SNOW64_INSTR_FETCH_PERF_CNT_EN
    logic [31:0] out_perf_empty_cycles;
    logic [15:0] out_perf_discards;
`endif

    snow64_instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_redirect_valid (in_redirect_valid),
        .in_redirect_pc    (in_redirect_pc),
        .out_mem_req_valid (out_mem_req_valid),
        .out_mem_req_addr  (out_mem_req_addr),
        .in_mem_req_ready  (in_mem_req_ready),
        .in_mem_resp_valid (in_mem_resp_valid),
        .in_mem_resp_data  (in_mem_resp_data),
        .out_instr_valid   (out_instr_valid),
        .out_instr         (out_instr),
        .out_instr_pc      (out_instr_pc),
        .in_decoder_ready  (in_decoder_ready)
`ifdef SNOW64_INSTR_FETCH_PERF_CNT_EN
        ,
        .out_perf_empty_cycles (out_perf_empty_cycles),
        .out_perf_discards     (out_perf_discards)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: instruction queue plus "one request outstanding, maybe stale".
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_fpc, m_inflight, m_req_addr;
    bit          m_req_vld, m_skip, m_out, m_stale;
    int unsigned m_empty, m_disc;

    // Memory responder
    bit          mem_busy;
    logic [63:0] mem_addr = '0;
    int          mem_dly, dly_min, dly_max;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] h(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        logic [63:0] rp;
        rp         = RPC;
        m_q.delete();
        m_fpc      = rp & ~64'h7;
        m_skip     = rp[2];
        m_req_addr = m_fpc;
        m_req_vld  = 0;
        m_out      = 0;
        m_stale    = 0;
        m_inflight = '0;
        m_empty    = 0;
        m_disc     = 0;
        mem_busy   = 0;
    endtask

    task automatic count_drop();
        if (m_disc < 16'hFFFF) m_disc++;
    endtask

    // One clock cycle: drive inputs, advance model, then check outputs at the next negedge.
    task automatic step(input bit redir, input logic [63:0] rpc, input bit mrdy,
                        input bit drdy, input bit inj);
        bit          rv, hs;
        logic [63:0] rd;
        ent_t        e;
        rv = inj || (mem_busy && mem_dly == 0);
        rd = inj ? 64'hDEAD_BEEF_0BAD_F00D : {h(mem_addr + 64'd4), h(mem_addr)};
        if (mem_busy) begin
            if (mem_dly == 0) mem_busy = 0;
            else mem_dly--;
        end
        if (out_mem_req_valid && mrdy) begin
            mem_busy = 1;
            mem_addr = out_mem_req_addr;
            mem_dly  = $urandom_range(dly_max, dly_min);
        end
        in_redirect_valid = redir;
        in_redirect_pc    = rpc;
        in_mem_req_ready  = mrdy;
        in_mem_resp_valid = rv;
        in_mem_resp_data  = rd;
        in_decoder_ready  = drdy;

        hs = m_req_vld && mrdy;
        if (m_q.size() == 0 && m_empty < 32'hFFFF_FFFF) m_empty++;
        if (redir) begin
            if (rv && m_out) begin
                m_out = 0;
                count_drop();
            end
            if (hs) m_out = 1;
            if (m_out) m_stale = 1;
            m_q.delete();
            m_fpc      = rpc & ~64'h7;
            m_skip     = rpc[2];
            m_req_addr = m_fpc;
            m_req_vld  = !m_out;
        end else begin
            if (drdy && m_q.size() > 0) void'(m_q.pop_front());
            if (rv && m_out) begin
                m_out = 0;
                if (m_stale) count_drop();
                else begin
                    if (!m_skip) begin
                        e.instr = rd[31:0];
                        e.pc    = m_inflight;
                        m_q.push_back(e);
                    end
                    e.instr = rd[63:32];
                    e.pc    = m_inflight + 64'd4;
                    m_q.push_back(e);
                    m_skip = 0;
                end
            end
            if (hs) begin
                m_out      = 1;
                m_stale    = 0;
                m_inflight = m_fpc;
                m_fpc      = m_fpc + 64'd8;
            end
            m_req_addr = m_fpc;
            m_req_vld  = !m_out && (m_q.size() <= DEPTH - 2);
        end

        @(negedge clk);
        chk("instr_valid", 64'(out_instr_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("instr", 64'(out_instr), 64'(m_q[0].instr));
            chk("instr_pc", out_instr_pc, m_q[0].pc);
        end
        chk("req_valid", 64'(out_mem_req_valid), 64'(m_req_vld));
        if (m_req_vld) chk("req_addr", out_mem_req_addr, m_req_addr);
`ifdef SNOW64_INSTR_FETCH_PERF_CNT_EN
        chk("perf_empty", 64'(out_perf_empty_cycles), 64'(m_empty));
        chk("perf_disc", 64'(out_perf_discards), 64'(m_disc));
`endif
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!out_mem_req_valid && n < 20) begin
            step(0, '0, 0, 1, 0);
            n++;
        end
        chk("wait_req_timeout", 64'(out_mem_req_valid), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(out_mem_req_valid), 64'd0);
        chk({tag, "_req_addr"}, out_mem_req_addr, RPC & ~64'h7);
        chk({tag, "_instr_valid"}, 64'(out_instr_valid), 64'd0);
        chk({tag, "_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_instr_pc"}, out_instr_pc, 64'd0);
`ifdef SNOW64_INSTR_FETCH_PERF_CNT_EN
        chk({tag, "_perf_empty"}, 64'(out_perf_empty_cycles), 64'd0);
        chk({tag, "_perf_disc"}, 64'(out_perf_discards), 64'd0);
`endif
    endtask

    initial begin
        int n;
        model_reset();
        dly_min = 0;
        dly_max = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // First request after reset, then both words streamed in order.
        step(0, '0, 0, 1, 0);
        chk("s1_req_valid", 64'(out_mem_req_valid), 64'd1);
        chk("s1_req_addr", out_mem_req_addr, 64'h1000);
        repeat (8) step(0, '0, 1, 1, 0);

        // Redirect to an odd-word PC: aligned request, low word skipped.
        wait_req();
        step(1, 64'h2004, 0, 1, 0);
        chk("s2_req_valid", 64'(out_mem_req_valid), 64'd1);
        chk("s2_req_addr", out_mem_req_addr, 64'h2000);
        repeat (6) step(0, '0, 1, 1, 0);

        // Redirect while waiting; stale response arrives 3 cycles later.
        wait_req();
        dly_min = 3;
        dly_max = 3;
        step(0, '0, 1, 1, 0);
        step(1, 64'h3000, 1, 1, 0);
        n = 0;
        while (!out_mem_req_valid && n < 10) begin
            step(0, '0, 1, 1, 0);
            n++;
        end
        chk("s3_req_valid", 64'(out_mem_req_valid), 64'd1);
        chk("s3_req_addr", out_mem_req_addr, 64'h3000);

        // Decode stall: queue fills, requests gate off, order survives.
        dly_min = 0;
        dly_max = 0;
        repeat (12) step(0, '0, 1, 0, 0);
        repeat (12) step(0, '0, 1, 1, 0);

        // Fetch PC wrap past 2^64.
        wait_req();
        step(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0);
        repeat (10) step(0, '0, 1, 1, 0);

        // Randomized traffic.
        dly_max = 3;
        for (int i = 0; i < 3000; i++) begin
            bit          rd_r;
            logic [63:0] pc_r;
            rd_r = ($urandom_range(0, 99) < 6);
            pc_r = {32'h0, $urandom_range(0, 32'hFFFF)};
            step(rd_r, pc_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 0);
        end

        // Reset mid-operation; a stray response in IDLE must be ignored.
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_rst");
        model_reset();
        in_mem_resp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, 0, 1, 1);
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 6), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
